// File: rtl/taxi_axis_dest_demux.sv
// taxi_axis_dest_demux
//   Splits one AXI4-Stream input into M_COUNT outputs packet by packet, using
//   the top CL_M_COUNT bits of tdest sampled on the first beat of each packet.
//   Packets with an out-of-range index are either discarded (DROP_INVALID = 1)
//   or sent to the last output. Every output has its own registered skid stage,
//   so no output tready reaches s_axis_tready_o combinationally.
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   s_axis_*_i/_o         input stream (tready is the only output)
//   m_axis_*_o            output streams, flattened, lane k at [k*W +: W]
//   m_axis_tready_i       per-output ready, bit k for output k
//   stat_drop             one-cycle pulse after the last beat of a dropped packet
module taxi_axis_dest_demux #(
   parameter int unsigned M_COUNT      = 4,
   parameter int unsigned DATA_W       = 8,
   parameter bit          KEEP_EN      = 1'b1,
   parameter int unsigned KEEP_W       = (DATA_W + 7) / 8,
   parameter bit          STRB_EN      = 1'b0,
   parameter bit          LAST_EN      = 1'b1,
   parameter bit          ID_EN        = 1'b0,
   parameter int unsigned ID_W         = 8,
   parameter bit          DEST_EN      = 1'b1,
   parameter int unsigned DEST_W       = 8,
   parameter bit          USER_EN      = 1'b0,
   parameter int unsigned USER_W       = 1,
   parameter bit          STRIP_DEST   = 1'b1,
   parameter bit          DROP_INVALID = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_W-1:0]           s_axis_tdata_i,
   input  logic [KEEP_W-1:0]           s_axis_tkeep_i,
   input  logic [KEEP_W-1:0]           s_axis_tstrb_i,
   input  logic                        s_axis_tvalid_i,
   output logic                        s_axis_tready_o,
   input  logic                        s_axis_tlast_i,
   input  logic [ID_W-1:0]             s_axis_tid_i,
   input  logic [DEST_W-1:0]           s_axis_tdest_i,
   input  logic [USER_W-1:0]           s_axis_tuser_i,
   output logic [M_COUNT*DATA_W-1:0]   m_axis_tdata_o,
   output logic [M_COUNT*KEEP_W-1:0]   m_axis_tkeep_o,
   output logic [M_COUNT*KEEP_W-1:0]   m_axis_tstrb_o,
   output logic [M_COUNT-1:0]          m_axis_tvalid_o,
   input  logic [M_COUNT-1:0]          m_axis_tready_i,
   output logic [M_COUNT-1:0]          m_axis_tlast_o,
   output logic [M_COUNT*ID_W-1:0]     m_axis_tid_o,
   output logic [M_COUNT*DEST_W-1:0]   m_axis_tdest_o,
   output logic [M_COUNT*USER_W-1:0]   m_axis_tuser_o,
   output logic                        stat_drop
);

   localparam int unsigned CL_M_COUNT = $clog2(M_COUNT);
   localparam int unsigned BEAT_W = DATA_W + 2*KEEP_W + 1 + ID_W + DEST_W + USER_W;

   if (M_COUNT < 2) begin : g_chk_count
      $fatal(1, "taxi_axis_dest_demux: M_COUNT must be at least 2");
   end
   if (!DEST_EN) begin : g_chk_dest_en
      $fatal(1, "taxi_axis_dest_demux: sink must carry tdest");
   end
   if (DEST_W < CL_M_COUNT) begin : g_chk_dest_w
      $fatal(1, "taxi_axis_dest_demux: tdest too narrow for output index");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DROP} state_t;

   state_t                 state_q;
   logic [CL_M_COUNT-1:0]  sel_q;
   logic                   stat_drop_q;
   logic                   init_q;

   logic [CL_M_COUNT-1:0]  idx;
   logic                   idx_valid;
   logic                   drop_first;
   logic [CL_M_COUNT-1:0]  sel_comb;
   logic [CL_M_COUNT-1:0]  route_sel;
   logic                   route_en;
   logic                   s_ready;
   logic                   accept;
   logic                   last_v;
   logic [KEEP_W-1:0]      keep_v;
   logic [KEEP_W-1:0]      strb_v;
   logic [ID_W-1:0]        id_v;
   logic [DEST_W-1:0]      dest_v;
   logic [USER_W-1:0]      user_v;
   logic [BEAT_W-1:0]      beat_in;
   logic [M_COUNT-1:0]     rdy_vec;

   logic unused_in;
   assign unused_in = ^{s_axis_tkeep_i, s_axis_tstrb_i, s_axis_tlast_i, s_axis_tid_i, s_axis_tuser_i};

   always_comb begin
      idx        = s_axis_tdest_i[DEST_W-1 -: CL_M_COUNT];
      idx_valid  = (32'(idx) < M_COUNT);
      drop_first = !idx_valid && DROP_INVALID;
      sel_comb   = idx_valid ? idx : CL_M_COUNT'(M_COUNT - 1);

      route_en  = 1'b0;
      route_sel = sel_q;
      s_ready   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drop_first) begin
               s_ready = 1'b1;
            end else begin
               route_en  = 1'b1;
               route_sel = sel_comb;
               s_ready   = rdy_vec[sel_comb];
            end
         end
         ST_ACTIVE: begin
            route_en = 1'b1;
            s_ready  = rdy_vec[sel_q];
         end
         ST_DROP: s_ready = 1'b1;
         default: s_ready = 1'b0;
      endcase
      // init_q keeps the drop path closed for the first cycle after reset too
      s_ready = s_ready && init_q && rst_n;

      last_v = LAST_EN ? s_axis_tlast_i : 1'b1;
      keep_v = KEEP_EN ? s_axis_tkeep_i : '1;
      strb_v = STRB_EN ? s_axis_tstrb_i : keep_v;
      id_v   = ID_EN ? s_axis_tid_i : '0;
      dest_v = DEST_EN ? s_axis_tdest_i : '0;
      if (STRIP_DEST) dest_v[DEST_W-1 -: CL_M_COUNT] = '0;
      user_v = USER_EN ? s_axis_tuser_i : '0;
      beat_in = {s_axis_tdata_i, keep_v, strb_v, last_v, id_v, dest_v, user_v};
   end

   assign s_axis_tready_o = s_ready;
   assign accept          = s_axis_tvalid_i && s_ready;
   assign stat_drop       = stat_drop_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         stat_drop_q <= 1'b0;
         init_q      <= 1'b0;
      end else begin
         init_q      <= 1'b1;
         stat_drop_q <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_IDLE: begin
                  if (drop_first) begin
                     if (last_v) stat_drop_q <= 1'b1;
                     else        state_q     <= ST_DROP;
                  end else begin
                     sel_q <= sel_comb;
                     if (!last_v) state_q <= ST_ACTIVE;
                  end
               end
               ST_ACTIVE: if (last_v) state_q <= ST_IDLE;
               ST_DROP: begin
                  if (last_v) begin
                     state_q     <= ST_IDLE;
                     stat_drop_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar k = 0; k < M_COUNT; k++) begin : g_out
      logic [BEAT_W-1:0] out_q;
      logic [BEAT_W-1:0] temp_q;
      logic              out_valid_q;
      logic              temp_valid_q;
      logic              rdy_q;
      logic              int_valid;
      logic              rdy_early;

      assign int_valid = accept && route_en && (route_sel == CL_M_COUNT'(k));
      assign rdy_early = m_axis_tready_i[k] || (!temp_valid_q && (!out_valid_q || !int_valid));
      assign rdy_vec[k] = rdy_q;

      // With rdy_q high the temp register is always empty, so a new beat goes
      // either straight to the output or into temp; temp drains first otherwise.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            out_valid_q  <= 1'b0;
            temp_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
         end else begin
            rdy_q <= rdy_early;
            if (rdy_q) begin
               if (m_axis_tready_i[k] || !out_valid_q) begin
                  out_valid_q <= int_valid;
                  out_q       <= beat_in;
               end else begin
                  temp_valid_q <= int_valid;
                  temp_q       <= beat_in;
               end
            end else if (m_axis_tready_i[k]) begin
               out_valid_q  <= temp_valid_q;
               out_q        <= temp_q;
               temp_valid_q <= 1'b0;
            end
         end
      end

      assign m_axis_tvalid_o[k] = out_valid_q;
      assign {m_axis_tdata_o[k*DATA_W +: DATA_W], m_axis_tkeep_o[k*KEEP_W +: KEEP_W],
              m_axis_tstrb_o[k*KEEP_W +: KEEP_W], m_axis_tlast_o[k],
              m_axis_tid_o[k*ID_W +: ID_W], m_axis_tdest_o[k*DEST_W +: DEST_W],
              m_axis_tuser_o[k*USER_W +: USER_W]} = out_q;
   end

endmodule
